// File: rtl/dma_pkg.sv
// Shared DMA datapath widths used by the beat packer and the write-side FIFO.
package dma_pkg;
  localparam int unsigned DMA_WORD_W = 64;
  localparam int unsigned DMA_BEAT_W = 256;
  localparam int unsigned DMA_STRB_W = DMA_BEAT_W / 8;
endpackage

// File: rtl/dma_beat_out_reg.sv
// Output holding register for packed beats: valid/ready handshake, load and flush.
module dma_beat_out_reg
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W = DMA_BEAT_W,
  parameter int unsigned STRB_W = DMA_STRB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [STRB_W-1:0] load_strb,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [STRB_W-1:0] out_strb,
  output logic              out_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload only moves on load, so it stays stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_strb <= '0;
    end else if (load && !flush) begin
      out_data <= load_data;
      out_strb <= load_strb;
    end
  end

endmodule

// File: rtl/dma_beat_packer.sv
// Width upsizer: packs RATIO narrow words into one wide beat with strobes and last.
module dma_beat_packer
  import dma_pkg::*;
#(
  parameter int unsigned IN_W  = DMA_WORD_W,
  parameter int unsigned RATIO = DMA_BEAT_W / DMA_WORD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [IN_W-1:0]           in_data,
  input  logic [IN_W/8-1:0]         in_strb,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [IN_W*RATIO-1:0]     out_data,
  output logic [IN_W*RATIO/8-1:0]   out_strb,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int unsigned OUT_W  = IN_W * RATIO;
  localparam int unsigned IN_SW  = IN_W / 8;
  localparam int unsigned OUT_SW = OUT_W / 8;
  localparam int unsigned CNT_W  = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]  cnt;
  logic [OUT_W-1:0]  acc_data;
  logic [OUT_SW-1:0] acc_strb;
  logic [OUT_W-1:0]  merged_data;
  logic [OUT_SW-1:0] merged_strb;
  logic              accept;
  logic              close;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign close    = accept && ((cnt == LAST_LANE) || in_last);
  assign busy     = (cnt != '0) || out_valid;

  // Unwritten lanes of the accumulator are always zero, so merging is a lane overwrite.
  always_comb begin
    merged_data = acc_data;
    merged_strb = acc_strb;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (cnt == CNT_W'(i)) begin
        merged_data[i*IN_W +: IN_W]   = in_data;
        merged_strb[i*IN_SW +: IN_SW] = in_strb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc_data <= '0;
      acc_strb <= '0;
    end else if (flush || close) begin
      cnt      <= '0;
      acc_data <= '0;
      acc_strb <= '0;
    end else if (accept) begin
      cnt      <= cnt + 1'b1;
      acc_data <= merged_data;
      acc_strb <= merged_strb;
    end
  end

  dma_beat_out_reg #(
    .DATA_W (OUT_W),
    .STRB_W (OUT_SW)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .load      (close),
    .load_data (merged_data),
    .load_strb (merged_strb),
    .load_last (in_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_strb  (out_strb),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_dma_beat_packer.sv
// Scoreboard bench for dma_beat_packer against a word-list reference model.
module tb_dma_beat_packer;
  localparam int unsigned IN_W  = 64;
  localparam int unsigned RATIO = 4;
  localparam int unsigned OUT_W = IN_W * RATIO;

  typedef struct {
    logic [OUT_W-1:0]   data;
    logic [OUT_W/8-1:0] strb;
    logic               last;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 in_valid;
  logic [IN_W-1:0]      in_data;
  logic [IN_W/8-1:0]    in_strb;
  logic                 in_last;
  logic                 in_ready;
  logic                 out_valid;
  logic [OUT_W-1:0]     out_data;
  logic [OUT_W/8-1:0]   out_strb;
  logic                 out_last;
  logic                 out_ready;
  logic                 busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [IN_W-1:0]   wd[$];
  logic [IN_W/8-1:0] ws[$];
  beat_t             exp_q[$];
  logic              pend = 1'b0;

  always #5 clk = ~clk;

  dma_beat_packer #(
    .IN_W  (IN_W),
    .RATIO (RATIO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_strb   (in_strb),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_strb  (out_strb),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference beat: the accepted words concatenated little-lane-first, missing lanes zero.
  task automatic close_beat(input logic last);
    beat_t b;
    b.data = '0;
    b.strb = '0;
    for (int i = 0; i < wd.size(); i++) begin
      b.data = b.data | (OUT_W'(wd[i]) << (IN_W * i));
      b.strb = b.strb | ((OUT_W/8)'(ws[i]) << ((IN_W/8) * i));
    end
    b.last = last;
    exp_q.push_back(b);
    wd.delete();
    ws.delete();
    pend = 1'b1;
  endtask

  task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic [IN_W/8-1:0] s,
                       input logic l, input logic ordy, input logic fl, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_strb   = s;
    in_last   = l;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = !pend || ordy;
    chk("in_ready", OUT_W'(in_ready), OUT_W'(exp_rdy));
    chk("out_valid", OUT_W'(out_valid), OUT_W'(pend));
    chk("busy", OUT_W'(busy), OUT_W'((wd.size() != 0) || pend));
    acc = v && exp_rdy && !fl;
    if (fl) begin
      wd.delete();
      ws.delete();
      exp_q.delete();
      pend = 1'b0;
    end else begin
      if (pend && ordy) pend = 1'b0;
      if (acc) begin
        wd.push_back(d);
        ws.push_back(s);
        if (wd.size() == RATIO || l) close_beat(l);
      end
    end
  endtask

  task automatic send_word(input logic [IN_W-1:0] d, input logic [IN_W/8-1:0] s, input logic l);
    logic acc;
    for (int t = 0; t < 20; t++) begin
      cycle(1'b1, d, s, l, 1'b1, 1'b0, acc);
      if (acc) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_word: word %h not accepted within 20 cycles", d);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  task automatic reset_mid;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", OUT_W'(out_valid), '0);
    chk("rst_busy", OUT_W'(busy), '0);
    chk("rst_out_strb", OUT_W'(out_strb), '0);
    wd.delete();
    ws.delete();
    exp_q.delete();
    pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every accepted output beat must match the oldest expected beat.
  always @(negedge clk) begin
    #2;
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_unexpected: got data %h with no beat expected", out_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_strb", OUT_W'(out_strb), OUT_W'(e.strb));
        chk("out_last", OUT_W'(out_last), OUT_W'(e.last));
      end
    end
  end

  initial begin
    logic acc;
    logic [7:0] b;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_strb   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", OUT_W'(out_valid), '0);
    chk("reset_busy", OUT_W'(busy), '0);
    chk("reset_out_data", out_data, '0);
    chk("reset_out_strb", OUT_W'(out_strb), '0);
    chk("reset_out_last", OUT_W'(out_last), '0);
    rst = 1'b0;

    // Full beat
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i * 17);
      send_word({8{b}}, 8'hFF, i == 4);
    end
    idle(2);

    // Partial beat closed by in_last
    send_word({8{8'hAA}}, 8'hFF, 1'b0);
    send_word({8{8'hBB}}, 8'hFF, 1'b1);
    idle(2);

    // Single-lane beat and zero-strobe lane
    send_word({8{8'hCC}}, 8'h0F, 1'b1);
    send_word({8{8'hDD}}, 8'h00, 1'b0);
    send_word({8{8'hEE}}, 8'hF0, 1'b1);
    idle(2);

    // Backpressure: stall 5 cycles with a word offered, then drain and stream
    for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'h1234, 8'hFF, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 8'hFF, i == 3);
    idle(2);

    // Back-to-back: 8 words
    for (int i = 0; i < 8; i++) send_word({$urandom, $urandom}, 8'($urandom), 1'b0);
    idle(2);

    // Flush mid-beat with a word offered
    for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 8'hFF, 1'b0);
    cycle(1'b1, 64'hDEAD, 8'hFF, 1'b0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 8'hFF, 1'b0);
    idle(2);

    // Reset mid-beat
    send_word({8{8'h55}}, 8'hFF, 1'b0);
    send_word({8{8'h66}}, 8'hFF, 1'b0);
    reset_mid();
    for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, 8'hFF, i == 3);
    idle(2);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 9) < 7, {$urandom, $urandom}, 8'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 39) == 0, acc);
    end

    idle(5);
    chk("drain_pending_beats", OUT_W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
